viterbi_dec: RTL and testbench
==============================

# viterbi_dec

Hard-decision Viterbi decoder for the rate-1/2 convolutional code produced by `convenc`. It is the receive-side counterpart of the encoder. It accepts one 2-bit code symbol per `dv_in` strobe and runs one add-compare-select step across all 2^(K-1) trellis states per symbol. It keeps survivors by register exchange and emits one decoded bit per symbol at a fixed delay of L symbols.

## Interface
- `K`, default 7: constraint length; must match the encoder. Number of states is S = 2^(K-1).
- `L`, default 32: survivor depth in symbols. Must be ≥ 5·(K-1).
- `M`, default 8: path metric width in bits. Metrics are modular.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `G`  in  `logic[K-1:0] G[1:0]`: generator polynomials, same packing as the encoder. Bit K-1 taps the newest input bit. Must be held static.
- `dv_in`  in  1: a code symbol is present this cycle.
- `din`  in  2: hard-decision symbol. `din[0]` is the parity of `G[0]`; `din[1]` is the parity of `G[1]`.
- `dv_out`  out  1: single-cycle strobe; `dout` is valid.
- `dout`  out  1: decoded information bit.

## Operation
- **Encoder model.** Encoder register u = {b, p}, where b is the new input bit and p is the previous K-1 bits (p[K-2] most recent). Codeword c[i] = ^(u & G[i]). The next state is n = {b, p[K-2:1]}.
- **Predecessors.** State n has predecessors p0 = {n[K-3:0],0} and p1 = {n[K-3:0],1}, both with input b = n[K-2].
- **Branch metric.** Hamming distance between `din` and the expected codeword, range 0..2.
- **ACS, per state n.** Compute cand_x = PM[p_x] + BM_x modulo 2^M. Select cand_1 only if it is strictly smaller, using modular compare: signed(cand_1 − cand_0) < 0. On a tie, select p0.
- **Path register.** Each state holds an L-bit path. New path[n] = {path[p_sel][L-2:0], n[K-2]}. Bit L-1 is the oldest.
- **Best state.** `best` is a registered index of the minimum new PM over all states, using the same modular compare. On a tie, the lowest index wins.
- **Output.** At a `dv_in` for symbol index k (counted from reset), if k ≥ L, then in the next cycle `dv_out`=1 and `dout` = pre-update path[`best`][L-1]. This is the decoded bit for symbol k−L.
- **Output suppression.** A saturating fill counter suppresses `dv_out` for the first L symbols after reset.
- **Idle cycles.** With `dv_in`=0, no PM, path, `best` or counter changes. `dv_out`=0 the next cycle.
- **Reset values.**
  - PM[0]=0 and all other PM = 2^(M-3); this keeps the initial spread below 2^(M-1).
  - All paths = 0, `best`=0, fill counter = 0.
  - `dv_out`=0, `dout`=0.
- **Reset mid-stream.** Reset aborts decoding immediately. Any in-flight output is dropped and the first L symbols after release are suppressed again.
- **Metric wrap.** PM values wrap freely; no normalization logic is needed. The maximum PM spread is 2·(K-1) < 2^(M-1).

## Timing
- Throughput: one symbol per clock, and `dv_in` may be asserted every cycle.
- Latency:
  - Decoded bit j: `dv_out` is asserted 1 cycle after the clock edge that accepts symbol j+L.
  - Under back-to-back input, that is L+1 cycles after symbol j.
- The ACS for all S states, path update and `best` computation complete in a single cycle.
- `dv_out` is exactly one cycle wide per accepted symbol with k ≥ L, never otherwise.
- `dv_in` during reset is ignored. The first symbol accepted is on the first edge with `rst`=0.

## Test plan
- **Error-free stream.**
  - Stimulus: encode 10 zeros, then the 120-bit pattern 0xFFF0CCAA000F3355E3ECDF8A1C1340, then 10 zeros, with `G`=171/133 octal and `dv_in` continuous.
  - Required response: the `dout` sequence equals the encoder input delayed by L=32 symbols, with zero mismatches.
  - Required response: the first `dv_out` appears 1 cycle after the 33rd symbol.
- **Sparse errors.** Same stream with one symbol bit flipped every 20 symbols (`din[k%2]` inverted) → zero decoded-bit errors.
- **Gapped input.** Same stream with `dv_in` deasserted for 1–3 random cycles between symbols → identical `dout` sequence. `dv_out` is never asserted in a gap+1 cycle.
- **Reset mid-stream.**
  - Stimulus: assert `rst` for 2 cycles after symbol 60, then restart the stream from its beginning.
  - Required response: `dv_out`=0 and `dout`=0 during reset.
  - Required response: no `dv_out` for 32 symbols after release, then output is error-free.
- **Metric wrap.** 5000 random info bits, encoded, with a 2% random bit-error rate and errors spaced ≥ 15 symbols → zero decoded errors across multiple PM wraps. This is checked against a reference model.
- **All-zero input.** `din`=00 continuous → `dout`=0 always, `best` stays 0, and PM[0] stays 0.

Source files
------------

// File: rtl/viterbi_dec.sv
// Hard-decision, register-exchange Viterbi decoder for the rate-1/2 code from convenc.
// One full-trellis ACS step per accepted symbol; decoded bits emerge L symbols late.
module viterbi_dec #(
    parameter int K = 7,
    parameter int L = 32,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] G [1:0],
    input  logic         dv_in,
    input  logic [1:0]   din,
    output logic         dv_out,
    output logic         dout
);
    localparam int S  = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam int FW = $clog2(L + 1);

    logic [M-1:0]  pm_q   [S];
    logic [M-1:0]  pm_d   [S];
    logic [L-1:0]  path_q [S];
    logic [L-1:0]  path_d [S];
    logic [SW-1:0] best_q, best_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          dv_out_q, dv_out_d;
    logic          dout_q, dout_d;

    logic [1:0]    cw       [2*S];
    logic [1:0]    bm       [2*S];
    logic [M-1:0]  cand0    [S];
    logic [M-1:0]  cand1    [S];
    logic [M-1:0]  new_pm   [S];
    logic [L-1:0]  new_path [S];
    logic [M-1:0]  acs_diff;
    logic          take1;
    logic [SW-1:0] best_idx;
    logic [M-1:0]  best_pm;
    logic [M-1:0]  best_diff;

    function automatic logic [1:0] hamming2(input logic [1:0] x);
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    // Transition index {n, x} is exactly the encoder register {b, p} of that branch.
    always_comb begin
        for (int t = 0; t < 2*S; t++) begin
            cw[t] = {^(K'(t) & G[1]), ^(K'(t) & G[0])};
            bm[t] = hamming2(din ^ cw[t]);
        end
    end

    always_comb begin
        acs_diff = '0;
        take1    = 1'b0;
        for (int n = 0; n < S; n++) begin
            cand0[n] = pm_q[(2*n) % S]     + M'(bm[2*n]);
            cand1[n] = pm_q[(2*n + 1) % S] + M'(bm[2*n + 1]);
            acs_diff = cand1[n] - cand0[n];
            take1    = acs_diff[M-1];
            new_pm[n] = take1 ? cand1[n] : cand0[n];
            new_path[n] = {take1 ? path_q[(2*n + 1) % S][L-2:0] : path_q[(2*n) % S][L-2:0],
                           1'(n >> (K - 2))};
        end
    end

    // Strict modular less-than keeps the lowest index on ties.
    always_comb begin
        best_idx  = '0;
        best_pm   = new_pm[0];
        best_diff = '0;
        for (int n = 1; n < S; n++) begin
            best_diff = new_pm[n] - best_pm;
            if (best_diff[M-1]) begin
                best_idx = SW'(n);
                best_pm  = new_pm[n];
            end
        end
    end

    always_comb begin
        pm_d     = pm_q;
        path_d   = path_q;
        best_d   = best_q;
        fill_d   = fill_q;
        dv_out_d = 1'b0;
        dout_d   = 1'b0;
        if (dv_in) begin
            pm_d   = new_pm;
            path_d = new_path;
            best_d = best_idx;
            if (fill_q == FW'(L)) begin
                dv_out_d = 1'b1;
                dout_d   = path_q[best_q][L-1];
            end else begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Non-zero start states sit at 2^(M-3) so the initial spread stays well inside half range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < S; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : M'(1 << (M - 3));
                path_q[s] <= '0;
            end
            best_q   <= '0;
            fill_q   <= '0;
            dv_out_q <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            pm_q     <= pm_d;
            path_q   <= path_d;
            best_q   <= best_d;
            fill_q   <= fill_d;
            dv_out_q <= dv_out_d;
            dout_q   <= dout_d;
        end
    end

    assign dv_out = dv_out_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_viterbi_dec.sv
// Self-checking bench for viterbi_dec: integer-metric traceback reference model,
// zero-input vector table, clean/noisy/gapped/reset streams and a long random run.
module tb_viterbi_dec;
    localparam int K = 7;
    localparam int L = 32;
    localparam int M = 8;
    localparam int S = 1 << (K - 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [K-1:0] G [1:0];
    logic         dv_in = 1'b0;
    logic [1:0]   din = 2'b00;
    logic         dv_out;
    logic         dout;

    viterbi_dec #(.K(K), .L(L), .M(M)) dut (
        .clk(clk), .rst(rst), .G(G), .dv_in(dv_in), .din(din),
        .dv_out(dv_out), .dout(dout)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    int  mpm [S];
    bit  dec_ring [L][S];
    int  mbest, mcount;
    int  enc_p, acc;
    bit  seen_first;
    bit  info_hist [8192];
    logic [119:0] pat;

    typedef struct {
        bit       v;
        bit [1:0] d;
        bit       edv;
        bit       edo;
    } zvec_t;
    zvec_t zv [48];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (accepted=%0d t=%0t)", name, act, exp, acc, $time);
        end
    endtask

    function automatic int enc_sym(input int p, input int b);
        int u, c0, c1;
        u  = (b << (K - 1)) | p;
        c0 = $countones(u & int'(G[0])) & 1;
        c1 = $countones(u & int'(G[1])) & 1;
        return (c1 << 1) | c0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < S; s++) mpm[s] = (s == 0) ? 0 : (1 << (M - 3));
        mbest = 0;
        mcount = 0;
        enc_p = 0;
        acc = 0;
        seen_first = 0;
    endtask

    // Unbounded integer metrics plus explicit traceback over stored decisions.
    task automatic model_step(input bit [1:0] d, output bit edv, output bit edo);
        int nw [S];
        int s, t, p0, p1, c0, c1;
        edv = 0;
        edo = 0;
        if (mcount >= L) begin
            s = mbest;
            t = mcount - 1;
            for (int i = 0; i < L - 1; i++) begin
                s = ((s << 1) % S) | int'(dec_ring[t % L][s]);
                t--;
            end
            edv = 1;
            edo = bit'((s >> (K - 2)) & 1);
        end
        for (int n = 0; n < S; n++) begin
            p0 = (n << 1) % S;
            p1 = p0 | 1;
            c0 = mpm[p0] + $countones(enc_sym(p0, n >> (K - 2)) ^ int'(d));
            c1 = mpm[p1] + $countones(enc_sym(p1, n >> (K - 2)) ^ int'(d));
            if (c1 < c0) begin
                nw[n] = c1;
                dec_ring[mcount % L][n] = 1;
            end else begin
                nw[n] = c0;
                dec_ring[mcount % L][n] = 0;
            end
        end
        mbest = 0;
        for (int n = 1; n < S; n++) if (nw[n] < nw[mbest]) mbest = n;
        mpm = nw;
        mcount++;
    endtask

    task automatic cycle(input bit v, input bit [1:0] d);
        bit edv, edo;
        int k;
        edv = 0;
        edo = 0;
        k = acc;
        @(negedge clk);
        dv_in = v;
        din = d;
        if (v) begin
            model_step(d, edv, edo);
            acc++;
        end
        @(posedge clk);
        #1;
        check("dv_out", 32'(dv_out), 32'(edv));
        if (edv) begin
            check("dout_vs_model", 32'(dout), 32'(edo));
            check("dout_vs_info", 32'(dout), 32'(info_hist[k - L]));
        end
        if (dv_out === 1'b1 && !seen_first) begin
            seen_first = 1;
            check("first_dv_out_after_symbols", 32'(acc), 32'(L + 1));
        end
    endtask

    task automatic send_bit(input bit b, input bit flip);
        int sym;
        sym = enc_sym(enc_p, int'(b));
        enc_p = (int'(b) << (K - 2)) | (enc_p >> 1);
        if (flip) sym = sym ^ (1 << (acc % 2));
        info_hist[acc] = b;
        cycle(1'b1, 2'(sym));
    endtask

    task automatic apply_reset(input int ncyc);
        @(negedge clk);
        rst = 1'b1;
        dv_in = 1'b1;
        din = 2'($urandom);
        #1;
        check("rst_dv_out", 32'(dv_out), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            check("rst_dv_out_hold", 32'(dv_out), 32'd0);
            check("rst_dout_hold", 32'(dout), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        dv_in = 1'b0;
        model_reset();
    endtask

    function automatic bit stream_bit(input int i);
        logic [119:0] p;
        p = pat;
        if (i < 10 || i >= 130) return 1'b0;
        return p[119 - (i - 10)];
    endfunction

    task automatic run_stream(input int flip_period, input int gap_max, input int stop_at);
        for (int i = 0; i < 140; i++) begin
            if (i == stop_at) return;
            send_bit(stream_bit(i), flip_period > 0 && (i % flip_period) == 10);
            if (gap_max > 0) repeat ($urandom_range(1, gap_max)) cycle(1'b0, 2'($urandom));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, next_err;
        bit flip;
        G[0] = 7'o171;
        G[1] = 7'o133;
        pat = 120'hFFF0CCAA000F3355E3ECDF8A1C1340;
        model_reset();

        rst = 1'b1;
        dv_in = 1'b1;
        din = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dv_out", 32'(dv_out), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_best", 32'(dut.best_q), 32'd0);
        check("reset_pm0", 32'(dut.pm_q[0]), 32'd0);
        check("reset_pm5", 32'(dut.pm_q[5]), 32'(1 << (M - 3)));
        @(negedge clk);
        rst = 1'b0;
        dv_in = 1'b0;

        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            zv[i].v   = (i % 9) != 4;
            zv[i].d   = 2'b00;
            zv[i].edv = zv[i].v && (cnt >= L);
            zv[i].edo = 1'b0;
            if (zv[i].v) cnt++;
        end
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            dv_in = zv[i].v;
            din = zv[i].d;
            @(posedge clk);
            #1;
            check("zero_dv_out", 32'(dv_out), 32'(zv[i].edv));
            check("zero_dout", 32'(dout), 32'(zv[i].edo));
            check("zero_best", 32'(dut.best_q), 32'd0);
            check("zero_pm0", 32'(dut.pm_q[0]), 32'd0);
        end

        apply_reset(2);
        run_stream(0, 0, -1);
        check("clean_first_dv_out_seen", 32'(seen_first), 32'd1);

        apply_reset(2);
        run_stream(20, 0, -1);

        apply_reset(2);
        run_stream(0, 3, -1);

        apply_reset(2);
        run_stream(0, 0, 61);
        apply_reset(2);
        run_stream(0, 0, -1);

        apply_reset(2);
        next_err = $urandom_range(15, 35);
        for (int i = 0; i < 5000; i++) begin
            flip = (i == next_err);
            if (flip) next_err += $urandom_range(15, 35);
            send_bit(1'($urandom_range(0, 1)), flip);
        end
        cycle(1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
